// File: rtl/pipe_ctrl.sv
// Control and hazard unit for the 4-stage IF/RF/EX/WB pipeline: valid tracking, decode, interlock, flush, drain.
// Optional build macro PIPE_FORWARDING_EN replaces EX/WB interlocks with operand forwarding.
module pipe_ctrl #(
  parameter int NUM_REGS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       N,
  input  logic       Z,
  input  logic [7:0] ir_rf,
  input  logic [7:0] ir_ex,
  input  logic [7:0] ir_wb,
  output logic       PCWrite,
  output logic       PCsel,
  output logic       IRLoad,
  output logic       IR3Load,
  output logic       IR4Load,
  output logic       R1R2Load,
  output logic       R1Sel,
  output logic       ALU1,
  output logic [2:0] ALU2,
  output logic [2:0] ALUop,
  output logic       ALU3,
  output logic       FlagWrite,
  output logic       MemWrite,
  output logic       WBenable,
  output logic       RFWrite,
  output logic       IncCount,
  output logic       halted,
  output logic [1:0] fwd1,
  output logic [1:0] fwd2
);

  localparam int RW = $clog2(NUM_REGS);
  localparam logic [RW-1:0] K1 = RW'(1);

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_NAND  = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SHIFT = 3'd4;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  typedef enum logic [3:0] {
    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND, OP_BZ, OP_BNZ, OP_BPZ,
    OP_STOP, OP_NOP, OP_SHIFT, OP_ORI
  } op_t;

  // Unlisted encodings fall through to nop so they never write or read registers.
  function automatic op_t decode(input logic [3:0] opc);
    op_t op;
    op = OP_NOP;
    if (opc[2:0] == 3'b111) begin
      op = OP_ORI;
    end else if (opc[2:0] == 3'b011) begin
      op = OP_SHIFT;
    end else begin
      case (opc)
        4'b0000: op = OP_LOAD;
        4'b0010: op = OP_STORE;
        4'b0100: op = OP_ADD;
        4'b0110: op = OP_SUB;
        4'b1000: op = OP_NAND;
        4'b0101: op = OP_BZ;
        4'b1001: op = OP_BNZ;
        4'b1101: op = OP_BPZ;
        4'b0001: op = OP_STOP;
        default: op = OP_NOP;
      endcase
    end
    return op;
  endfunction

  function automatic logic writes_reg(input op_t op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_NAND, OP_SHIFT, OP_ORI};
  endfunction

  function automatic logic reads_r1(input op_t op);
    return op inside {OP_ADD, OP_SUB, OP_NAND, OP_STORE, OP_SHIFT, OP_ORI};
  endfunction

  function automatic logic reads_r2(input op_t op);
    return op inside {OP_ADD, OP_SUB, OP_NAND, OP_STORE, OP_LOAD};
  endfunction

  state_t state, state_nx;
  logic v_rf, v_ex, v_wb;
  logic v_rf_nx, v_ex_nx, v_wb_nx;

  op_t op_rf, op_ex, op_wb;
  logic [RW-1:0] rf_a1, rf_a2, ex_wa, wb_wa;
  logic rf_rd1, rf_rd2, ex_wr, wb_wr;
  logic m1_ex, m2_ex, m1_wb, m2_wb;
  logic hazard, br_taken, rf_stop;
  logic unused_ok;

  assign op_rf = decode(ir_rf[3:0]);
  assign op_ex = decode(ir_ex[3:0]);
  assign op_wb = decode(ir_wb[3:0]);

  assign rf_a1 = (op_rf == OP_ORI) ? K1 : ir_rf[7 -: RW];
  assign rf_a2 = ir_rf[5 -: RW];
  assign ex_wa = (op_ex == OP_ORI) ? K1 : ir_ex[7 -: RW];
  assign wb_wa = (op_wb == OP_ORI) ? K1 : ir_wb[7 -: RW];
  assign unused_ok = ^{ir_ex[5:4], ir_wb[5:4]};

  assign rf_rd1 = v_rf & reads_r1(op_rf);
  assign rf_rd2 = v_rf & reads_r2(op_rf);
  assign ex_wr  = v_ex & writes_reg(op_ex);
  assign wb_wr  = v_wb & writes_reg(op_wb);

  assign m1_ex = rf_rd1 & ex_wr & (rf_a1 == ex_wa);
  assign m2_ex = rf_rd2 & ex_wr & (rf_a2 == ex_wa);
  assign m1_wb = rf_rd1 & wb_wr & (rf_a1 == wb_wa);
  assign m2_wb = rf_rd2 & wb_wr & (rf_a2 == wb_wa);

`ifdef PIPE_FORWARDING_EN
  // Load data only exists after memory, so a load in EX still costs one bubble.
  assign hazard = (m1_ex | m2_ex) & (op_ex == OP_LOAD);
  assign fwd1   = m1_ex ? 2'd1 : (m1_wb ? 2'd2 : 2'd0);
  assign fwd2   = m2_ex ? 2'd1 : (m2_wb ? 2'd2 : 2'd0);
`else
  // The register file has no write-through, so a WB writer also interlocks.
  assign hazard = m1_ex | m2_ex | m1_wb | m2_wb;
  assign fwd1   = 2'd0;
  assign fwd2   = 2'd0;
`endif

  assign br_taken = v_ex & (((op_ex == OP_BZ)  &  Z) |
                            ((op_ex == OP_BNZ) & ~Z) |
                            ((op_ex == OP_BPZ) & ~N));
  assign rf_stop  = v_rf & (op_rf == OP_STOP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      v_rf  <= 1'b0;
      v_ex  <= 1'b0;
      v_wb  <= 1'b0;
    end else begin
      state <= state_nx;
      v_rf  <= v_rf_nx;
      v_ex  <= v_ex_nx;
      v_wb  <= v_wb_nx;
    end
  end

  always_comb begin
    state_nx = state;
    v_rf_nx  = 1'b0;
    v_ex_nx  = 1'b0;
    v_wb_nx  = v_ex;
    PCWrite  = 1'b0;
    PCsel    = 1'b1;
    IRLoad   = 1'b0;
    IR3Load  = 1'b0;
    IR4Load  = 1'b0;
    R1R2Load = 1'b0;
    case (state)
      RUN: begin
        IR3Load = 1'b1;
        IR4Load = 1'b1;
        if (br_taken) begin
          PCWrite  = 1'b1;
          PCsel    = 1'b0;
          IRLoad   = 1'b1;
          R1R2Load = 1'b1;
        end else if (hazard) begin
          v_rf_nx = v_rf;
        end else if (rf_stop) begin
          state_nx = DRAIN;
          R1R2Load = 1'b1;
        end else begin
          PCWrite  = 1'b1;
          IRLoad   = 1'b1;
          R1R2Load = 1'b1;
          v_rf_nx  = 1'b1;
          v_ex_nx  = v_rf;
        end
      end
      DRAIN: begin
        IR3Load  = 1'b1;
        IR4Load  = 1'b1;
        R1R2Load = 1'b1;
        if (!v_ex && !v_wb) state_nx = HALT;
      end
      HALT: begin
        v_wb_nx = 1'b0;
      end
      default: state_nx = RUN;
    endcase
    // Hold the datapath frozen while reset is asserted, not just after the edge.
    if (!reset) begin
      PCWrite  = 1'b0;
      IRLoad   = 1'b0;
      IR3Load  = 1'b0;
      IR4Load  = 1'b0;
      R1R2Load = 1'b0;
    end
  end

  always_comb begin
    ALU1      = 1'b0;
    ALU2      = 3'd0;
    ALUop     = ALU_ADD;
    ALU3      = 1'b0;
    FlagWrite = 1'b0;
    MemWrite  = 1'b0;
    if (v_ex) begin
      case (op_ex)
        OP_ADD:   begin ALU1 = 1'b1; ALUop = ALU_ADD;  FlagWrite = 1'b1; end
        OP_SUB:   begin ALU1 = 1'b1; ALUop = ALU_SUB;  FlagWrite = 1'b1; end
        OP_NAND:  begin ALU1 = 1'b1; ALUop = ALU_NAND; FlagWrite = 1'b1; end
        OP_ORI:   begin ALU1 = 1'b1; ALU2 = 3'd3; ALUop = ALU_OR;    FlagWrite = 1'b1; end
        OP_SHIFT: begin ALU1 = 1'b1; ALU2 = 3'd4; ALUop = ALU_SHIFT; FlagWrite = 1'b1; end
        OP_LOAD:  ALU3 = 1'b1;
        OP_STORE: MemWrite = 1'b1;
        OP_BZ, OP_BNZ, OP_BPZ: begin
          if (br_taken) begin
            ALU1  = 1'b0;
            ALU2  = 3'd2;
            ALUop = ALU_ADD;
          end
        end
        default: ;
      endcase
    end
  end

  assign WBenable = ex_wr;
  assign RFWrite  = wb_wr;
  assign IncCount = v_wb & (op_wb != OP_STOP);
  assign R1Sel    = v_rf & (op_rf == OP_ORI);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: drives the stage instruction registers cycle by cycle and checks control outputs.
// Build with +define+PIPE_FORWARDING_EN to exercise the forwarding variant.
module tb_pipe_ctrl;

  localparam logic [7:0] NOP     = 8'h0A;
  localparam logic [7:0] ADD01   = 8'h14;
  localparam logic [7:0] SUB20   = 8'h86;
  localparam logic [7:0] STORE23 = 8'hB2;
  localparam logic [7:0] LOAD30  = 8'hC0;
  localparam logic [7:0] STOP    = 8'h01;
  localparam logic [7:0] BZ      = 8'h25;
  localparam logic [7:0] BNZ     = 8'h29;

  logic       clock = 1'b0;
  logic       reset, N, Z;
  logic [7:0] ir_rf, ir_ex, ir_wb;
  logic       PCWrite, PCsel, IRLoad, IR3Load, IR4Load, R1R2Load, R1Sel, ALU1;
  logic [2:0] ALU2, ALUop;
  logic       ALU3, FlagWrite, MemWrite, WBenable, RFWrite, IncCount, halted;
  logic [1:0] fwd1, fwd2;

  int   checks = 0;
  int   errors = 0;
  int   inc_cnt = 0;
  int   mem_cnt = 0;
  logic count_on = 1'b0;

  pipe_ctrl dut (
    .clock(clock), .reset(reset), .N(N), .Z(Z),
    .ir_rf(ir_rf), .ir_ex(ir_ex), .ir_wb(ir_wb),
    .PCWrite(PCWrite), .PCsel(PCsel), .IRLoad(IRLoad), .IR3Load(IR3Load),
    .IR4Load(IR4Load), .R1R2Load(R1R2Load), .R1Sel(R1Sel), .ALU1(ALU1),
    .ALU2(ALU2), .ALUop(ALUop), .ALU3(ALU3), .FlagWrite(FlagWrite),
    .MemWrite(MemWrite), .WBenable(WBenable), .RFWrite(RFWrite),
    .IncCount(IncCount), .halted(halted), .fwd1(fwd1), .fwd2(fwd2)
  );

  always #5 clock = ~clock;

  // Retirement and store pulses are tallied mid-cycle for the drain test.
  always @(negedge clock) begin
    if (count_on) begin
      inc_cnt = inc_cnt + int'(IncCount);
      mem_cnt = mem_cnt + int'(MemWrite);
    end
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] rf, input logic [7:0] ex, input logic [7:0] wb);
    ir_rf = rf;
    ir_ex = ex;
    ir_wb = wb;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b0;
    applyStimulus(NOP, NOP, NOP);
    tick();
    reset = 1'b1;
    applyStimulus(NOP, NOP, NOP);
  endtask

  initial begin
    reset = 1'b0;
    N = 1'b0;
    Z = 1'b0;
    applyStimulus(NOP, NOP, NOP);
    $display("[TB] reset state");
    checkOutput("rst_pcwrite", PCWrite, 1'b0);
    checkOutput("rst_pcsel", PCsel, 1'b1);
    checkOutput("rst_irload", IRLoad, 1'b0);
    checkOutput("rst_ir3load", IR3Load, 1'b0);
    checkOutput("rst_r1r2load", R1R2Load, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_rfwrite", RFWrite, 1'b0);

    tick();
    reset = 1'b1;
    applyStimulus(NOP, NOP, NOP);
    checkOutput("rel_pcwrite", PCWrite, 1'b1);
    checkOutput("rel_pcsel", PCsel, 1'b1);
    checkOutput("rel_irload", IRLoad, 1'b1);

    $display("[TB] add k0,k1 then sub k2,k0");
    tick();
    applyStimulus(ADD01, SUB20, ADD01);
    checkOutput("c1_pcwrite", PCWrite, 1'b1);
    checkOutput("c1_flagwrite_bubble", FlagWrite, 1'b0);
    checkOutput("c1_rfwrite_bubble", RFWrite, 1'b0);
    tick();
    applyStimulus(SUB20, ADD01, NOP);
    checkOutput("c2_flagwrite", FlagWrite, 1'b1);
    checkOutput("c2_wbenable", WBenable, 1'b1);
`ifdef PIPE_FORWARDING_EN
    checkOutput("c2_pcwrite_fwd", PCWrite, 1'b1);
    checkValue("c2_fwd2", 8'(fwd2), 8'd1);
    checkValue("c2_fwd1", 8'(fwd1), 8'd0);
    tick();
    applyStimulus(STORE23, LOAD30, SUB20);
    checkOutput("lu_pcwrite_stall", PCWrite, 1'b0);
    checkValue("lu_fwd1_wb", 8'(fwd1), 8'd2);
    checkOutput("lu_alu3", ALU3, 1'b1);
    checkOutput("lu_rfwrite", RFWrite, 1'b1);
    tick();
    applyStimulus(STORE23, STORE23, LOAD30);
    checkOutput("lu2_pcwrite", PCWrite, 1'b1);
    checkValue("lu2_fwd2_wb", 8'(fwd2), 8'd2);
    checkValue("lu2_fwd1", 8'(fwd1), 8'd0);
`else
    checkOutput("c2_pcwrite_stall", PCWrite, 1'b0);
    checkOutput("c2_irload_stall", IRLoad, 1'b0);
    checkOutput("c2_r1r2load_stall", R1R2Load, 1'b0);
    tick();
    applyStimulus(SUB20, SUB20, ADD01);
    checkOutput("c3_pcwrite_stall", PCWrite, 1'b0);
    checkOutput("c3_flagwrite_bubble", FlagWrite, 1'b0);
    checkOutput("c3_rfwrite", RFWrite, 1'b1);
    checkOutput("c3_inccount", IncCount, 1'b1);
    tick();
    applyStimulus(SUB20, SUB20, SUB20);
    checkOutput("c4_pcwrite_resume", PCWrite, 1'b1);
    checkOutput("c4_rfwrite", RFWrite, 1'b0);
    checkOutput("c4_inccount", IncCount, 1'b0);
`endif

    $display("[TB] reset mid-run");
    resetDut();
    tick();
    tick();
    tick();
    applyStimulus(NOP, STORE23, ADD01);
    checkOutput("full_memwrite", MemWrite, 1'b1);
    checkOutput("full_rfwrite", RFWrite, 1'b1);
    checkOutput("full_wbenable", WBenable, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("mid_pcwrite", PCWrite, 1'b0);
    checkOutput("mid_irload", IRLoad, 1'b0);
    checkOutput("mid_memwrite", MemWrite, 1'b0);
    checkOutput("mid_rfwrite", RFWrite, 1'b0);
    checkOutput("mid_pcsel", PCsel, 1'b1);
    tick();
    checkOutput("mid_next_pcwrite", PCWrite, 1'b0);
    checkOutput("mid_next_ir4load", IR4Load, 1'b0);
    checkOutput("mid_next_halted", halted, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_pcwrite", PCWrite, 1'b1);
    checkOutput("mid_rel_pcsel", PCsel, 1'b1);

    $display("[TB] branches");
    tick();
    tick();
    tick();
    Z = 1'b1;
    applyStimulus(ADD01, BZ, NOP);
    checkOutput("bz_pcsel", PCsel, 1'b0);
    checkOutput("bz_pcwrite", PCWrite, 1'b1);
    checkValue("bz_alu2", 8'(ALU2), 8'd2);
    checkOutput("bz_alu1", ALU1, 1'b0);
    tick();
    applyStimulus(STORE23, ADD01, BZ);
    checkOutput("sq_v_rf", dut.v_rf, 1'b0);
    checkOutput("sq_v_ex", dut.v_ex, 1'b0);
    checkOutput("sq_flagwrite", FlagWrite, 1'b0);
    checkOutput("sq_wbenable", WBenable, 1'b0);
    checkOutput("sq_branch_retires", IncCount, 1'b1);
    tick();
    applyStimulus(NOP, STORE23, ADD01);
    checkOutput("sq2_memwrite", MemWrite, 1'b0);
    checkOutput("sq2_rfwrite", RFWrite, 1'b0);
    checkOutput("sq2_inccount", IncCount, 1'b0);
    tick();
    applyStimulus(NOP, BNZ, NOP);
    checkOutput("bnz_pcsel", PCsel, 1'b1);
    checkOutput("bnz_pcwrite", PCWrite, 1'b1);
    tick();
    applyStimulus(STOP, BZ, BNZ);
    checkOutput("bzstop_pcsel", PCsel, 1'b0);
    checkOutput("bzstop_inccount", IncCount, 1'b1);
    tick();
    applyStimulus(NOP, STOP, BZ);
    checkOutput("bzstop_halted", halted, 1'b0);
    tick();
    applyStimulus(NOP, NOP, STOP);
    checkOutput("bzstop_run_pcwrite", PCWrite, 1'b1);
    checkOutput("bzstop_run_halted", halted, 1'b0);

    $display("[TB] stop drain");
    Z = 1'b0;
    resetDut();
    count_on = 1'b1;
    tick();
    applyStimulus(ADD01, NOP, NOP);
    tick();
    applyStimulus(STORE23, ADD01, NOP);
    checkOutput("dr_c2_pcwrite", PCWrite, 1'b1);
    tick();
    applyStimulus(STOP, STORE23, ADD01);
    checkOutput("dr_c3_memwrite", MemWrite, 1'b1);
    checkOutput("dr_c3_inccount", IncCount, 1'b1);
    tick();
    applyStimulus(STOP, STOP, STORE23);
    checkOutput("dr1_pcwrite", PCWrite, 1'b0);
    checkOutput("dr1_irload", IRLoad, 1'b0);
    checkOutput("dr1_inccount", IncCount, 1'b1);
    checkOutput("dr1_halted", halted, 1'b0);
    tick();
    applyStimulus(STOP, STOP, STOP);
    checkOutput("dr2_inccount", IncCount, 1'b0);
    checkOutput("dr2_halted", halted, 1'b0);
    tick();
    checkOutput("halt_halted", halted, 1'b1);
    checkOutput("halt_pcwrite", PCWrite, 1'b0);
    checkOutput("halt_ir3load", IR3Load, 1'b0);
    checkOutput("halt_r1r2load", R1R2Load, 1'b0);
    tick();
    checkOutput("halt_stays", halted, 1'b1);
    count_on = 1'b0;
    checkValue("drain_inccount_total", 8'(inc_cnt), 8'd2);
    checkValue("drain_memwrite_total", 8'(mem_cnt), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
